// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, timing constants and command codes
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_WAIT_FIRST,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ABORT
  } ps2_tx_state_t;

  // Line timing in 50 MHz system clock cycles
  localparam int T_INHIBIT_120US = 6000;
  localparam int T_RTS_5US       = 250;
  localparam int T_START_15MS    = 750000;
  localparam int T_FRAME_2MS     = 100000;

  // Scan code prefixes seen by the receiver
  localparam logic [7:0] PS2_RELEASE  = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED = 8'hE0;

  // Host-to-keyboard commands
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_DISABLE  = 8'hF5;
  localparam logic [7:0] CMD_RESEND   = 8'hFE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Odd parity: total count of ones over data plus parity is odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-FF synchronizer with rise/fall pulses for one PS/2 line
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // Two synchronizing stages plus one delayed copy for edge detection; lines idle high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = ~prev_q & sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES   = T_INHIBIT_120US,
  parameter int RTS_SETUP_CYCLES = T_RTS_5US,
  parameter int START_TIMEOUT    = T_START_15MS,
  parameter int FRAME_TIMEOUT    = T_FRAME_2MS,
  parameter int CNT_W            = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  output logic       rx_hold
);

  // Terminal counts: a phase of N cycles ends when the timer shows N-1
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST   = CNT_W'(RTS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

  ps2_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] timer_q, frame_q;
  logic [9:0]       sr_q;
  logic             line_bit_q;
  logic [3:0]       bit_cnt_q;
  logic             ack_int_q, ack_err_q, timeout_err_q;
  logic             clk_lvl, clk_fall, data_lvl;
  logic             unused_clk_rise, unused_data_rise, unused_data_fall;
  logic             clk_oe_c, data_oe_c, busy_c, done_c;
  logic             load, shift_en, ack_sample, start_exp, frame_exp;

  ps2_sync_edge u_sync_clk (
    .clk   (clk),
    .rst   (rst),
    .din   (ps2_clk_in),
    .level (clk_lvl),
    .rise  (unused_clk_rise),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk   (clk),
    .rst   (rst),
    .din   (ps2_data_in),
    .level (data_lvl),
    .rise  (unused_data_rise),
    .fall  (unused_data_fall)
  );

  assign start_exp = (timer_q >= START_LAST);
  assign frame_exp = (frame_q >= FRAME_LAST);

  // State register; async reset drops straight to IDLE so both lines release at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and line control; timeouts take priority over a coincident device clock fall
  always_comb begin
    state_d    = state_q;
    clk_oe_c   = 1'b0;
    data_oe_c  = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    ack_sample = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (tx_start) begin
          load    = 1'b1;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        clk_oe_c = 1'b1;
        if (timer_q == INH_LAST) state_d = ST_RTS;
      end
      ST_RTS: begin
        clk_oe_c  = 1'b1;
        data_oe_c = 1'b1;
        if (timer_q == RTS_LAST) state_d = ST_WAIT_FIRST;
      end
      ST_WAIT_FIRST: begin
        data_oe_c = 1'b1;
        if (start_exp) state_d = ST_ABORT;
        else if (clk_fall) begin
          shift_en = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        data_oe_c = ~line_bit_q;
        if (frame_exp) state_d = ST_ABORT;
        else if (clk_fall) begin
          shift_en = 1'b1;
          if (bit_cnt_q == 4'd9) state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        data_oe_c = ~line_bit_q;
        if (frame_exp) state_d = ST_ABORT;
        else if (clk_fall) begin
          ack_sample = 1'b1;
          state_d    = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (frame_exp) state_d = ST_ABORT;
        else if (clk_lvl && data_lvl) state_d = ST_DONE;
      end
      ST_DONE, ST_ABORT: begin
        busy_c = 1'b0;
        done_c = 1'b1;
        if (tx_start) begin
          load    = 1'b1;
          state_d = ST_INHIBIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase timer restarts on every state change; frame timer restarts on the first device fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      frame_q <= '0;
    end else begin
      if (state_d != state_q)  timer_q <= '0;
      else if (timer_q != '1)  timer_q <= timer_q + 1'b1;
      if (state_q == ST_WAIT_FIRST && state_d == ST_SEND) frame_q <= '0;
      else if (frame_q != '1)                             frame_q <= frame_q + 1'b1;
    end
  end

  // Frame shifter {stop, parity, data}: presents the next bit on each device clock fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '1;
      line_bit_q <= 1'b1;
      bit_cnt_q  <= '0;
      ack_int_q  <= 1'b0;
    end else begin
      if (load) begin
        sr_q       <= {1'b1, odd_parity(tx_data), tx_data};
        line_bit_q <= 1'b1;
        bit_cnt_q  <= '0;
        ack_int_q  <= 1'b0;
      end else if (shift_en) begin
        line_bit_q <= sr_q[0];
        sr_q       <= {1'b1, sr_q[9:1]};
        bit_cnt_q  <= bit_cnt_q + 4'd1;
      end
      if (ack_sample) ack_int_q <= data_lvl;
    end
  end

  // Completion flags: loaded on entry to DONE or ABORT and held until the next completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else if (state_q == ST_WAIT_IDLE && state_d == ST_DONE) begin
      ack_err_q     <= ack_int_q;
      timeout_err_q <= 1'b0;
    end else if (state_d == ST_ABORT) begin
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b1;
    end
  end

  assign ps2_clk_oe  = clk_oe_c;
  assign ps2_data_oe = data_oe_c;
  assign busy        = busy_c;
  assign rx_hold     = busy_c;
  assign done        = done_c;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;

endmodule
